// File: rtl/shift_reg_pair.sv
// Two WIDTH-bit registers fed from one serial input: Q1 broadcasts the latest
// sample to every bit, Q2 is an ordinary serial shift chain (bit 0 newest).
module shift_reg_pair #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             D,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2
);

    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q1_d;
    logic [WIDTH-1:0] q2_q;
    logic [WIDTH-1:0] q2_d;

    // A chain whose stages all see the new value at once collapses to a fan-out.
    assign q1_d = {WIDTH{D}};

    assign q2_d[0] = D;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
            assign q2_d[gi] = q2_q[gi-1];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Rst) begin
            q1_q <= '0;
        end else begin
            q1_q <= q1_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            q2_q <= '0;
        end else begin
            q2_q <= q2_d;
        end
    end

    assign Q1 = q1_q;
    assign Q2 = q2_q;

endmodule

// File: tb/tb_shift_reg_pair.sv
// Bench for shift_reg_pair at WIDTH 4, 8 and 1: directed vectors, edge-only
// capture sequences and random traffic against a sample-history model.
module tb_shift_reg_pair;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d   = 1'b0;
    logic [3:0] q1_4, q2_4;
    logic [7:0] q1_8, q2_8;
    logic [0:0] q1_1, q2_1;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference: list of D values sampled since the last reset, newest first.
    logic hist[$];
    logic last_d;

    always #100 clk = ~clk;

    shift_reg_pair #(.WIDTH(4)) dut4 (.Clk(clk), .Rst(rst), .D(d), .Q1(q1_4), .Q2(q2_4));
    shift_reg_pair #(.WIDTH(8)) dut8 (.Clk(clk), .Rst(rst), .D(d), .Q1(q1_8), .Q2(q2_8));
    shift_reg_pair #(.WIDTH(1)) dut1 (.Clk(clk), .Rst(rst), .D(d), .Q1(q1_1), .Q2(q2_1));

    typedef struct {
        logic       rst;
        logic       d;
        logic [3:0] q1;
        logic [3:0] q2;
    } vec_t;

    vec_t vecs[10];

    task automatic model_update(input logic r, input logic dv);
        if (r) begin
            hist.delete();
            last_d = 1'b0;
        end else begin
            hist.push_front(dv);
            if (hist.size() > 8) void'(hist.pop_back());
            last_d = dv;
        end
    endtask

    function automatic logic [7:0] exp_q2(input int w);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < w; k++)
            if (k < hist.size()) v[k] = hist[k];
        return v;
    endfunction

    function automatic logic [7:0] exp_q1(input int w);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < w; k++) v[k] = last_d;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic dv);
        rst = r;
        d   = dv;
        @(posedge clk);
        model_update(r, dv);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, " q1_w4"}, {4'b0, q1_4}, exp_q1(4));
        check({tag, " q2_w4"}, {4'b0, q2_4}, exp_q2(4));
        check({tag, " q1_w8"}, q1_8, exp_q1(8));
        check({tag, " q2_w8"}, q2_8, exp_q2(8));
        check({tag, " q1_w1"}, {7'b0, q1_1}, exp_q1(1));
        check({tag, " q2_w1"}, {7'b0, q2_1}, exp_q2(1));
    endtask

    initial begin
        last_d = 1'b0;
        vecs[0] = '{1'b1, 1'b1, 4'b0000, 4'b0000};
        vecs[1] = '{1'b0, 1'b1, 4'b1111, 4'b0001};
        vecs[2] = '{1'b0, 1'b0, 4'b0000, 4'b0010};
        vecs[3] = '{1'b0, 1'b1, 4'b1111, 4'b0101};
        vecs[4] = '{1'b0, 1'b0, 4'b0000, 4'b1010};
        vecs[5] = '{1'b0, 1'b1, 4'b1111, 4'b0101};
        vecs[6] = '{1'b0, 1'b1, 4'b1111, 4'b1011};
        vecs[7] = '{1'b0, 1'b0, 4'b0000, 4'b0110};
        vecs[8] = '{1'b0, 1'b0, 4'b0000, 4'b1100};
        vecs[9] = '{1'b0, 1'b1, 4'b1111, 4'b1001};

        // Directed table on the WIDTH=4 instance, with the model cross-checking all widths.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].d);
            $display("[TB] vec %0d rst=%b d=%b q1=%b q2=%b", i, vecs[i].rst, vecs[i].d, q1_4, q2_4);
            check($sformatf("vec%0d q1", i), {4'b0, q1_4}, {4'b0, vecs[i].q1});
            check($sformatf("vec%0d q2", i), {4'b0, q2_4}, {4'b0, vecs[i].q2});
            check_all($sformatf("vec%0d model", i));
        end

        // Mid-stream reset from Q2=1011 with D held high.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("pre_reset q2", {4'b0, q2_4}, 8'b0000_1011);
        step(1'b1, 1'b1);
        $display("[TB] reset mid-stream q1=%b q2=%b", q1_4, q2_4);
        check("midrst q1", {4'b0, q1_4}, 8'b0);
        check("midrst q2", {4'b0, q2_4}, 8'b0);
        check("midrst q2_w8", q2_8, 8'b0);
        step(1'b0, 1'b1);
        $display("[TB] after reset q1=%b q2=%b", q1_4, q2_4);
        check("postrst q1", {4'b0, q1_4}, 8'b0000_1111);
        check("postrst q2", {4'b0, q2_4}, 8'b0000_0001);

        // D pulse strictly between edges must not be captured.
        d = 1'b0;
        #50 d = 1'b1;
        #30 d = 1'b0;
        @(posedge clk);
        model_update(1'b0, 1'b0);
        #1;
        $display("[TB] glitch d q1=%b q2=%b", q1_4, q2_4);
        check("glitch q1", {4'b0, q1_4}, 8'b0);
        check("glitch q2", {4'b0, q2_4}, 8'b0000_0010);

        // Reset pulse strictly between edges must not clear anything.
        d = 1'b1;
        #50 rst = 1'b1;
        #30 rst = 1'b0;
        @(posedge clk);
        model_update(1'b0, 1'b1);
        #1;
        $display("[TB] glitch rst q1=%b q2=%b", q1_4, q2_4);
        check("rstglitch q1", {4'b0, q1_4}, 8'b0000_1111);
        check("rstglitch q2", {4'b0, q2_4}, 8'b0000_0101);

        // Single 1 walking through the WIDTH=8 chain.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            $display("[TB] walk %0d q2_w8=%b", k, q2_8);
            check($sformatf("walk%0d q2_w8", k), q2_8, 8'(1 << k));
            step(1'b0, 1'b0);
        end
        $display("[TB] walk end q2_w8=%b", q2_8);
        check("walk end q2_w8", q2_8, 8'b0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
            check_all($sformatf("rand%0d", n));
            check($sformatf("rand%0d w1 q1==q2", n), {7'b0, q1_1}, {7'b0, q2_1});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
